serial_addsub_nbit: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 37 +++
 rtl/serial_digit_adder.sv | 36 +++
 rtl/serial_addsub_nbit.sv | 146 ++++++++++++++
 tb/tb_serial_addsub_nbit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types and constant helpers for the bit-serial adder/subtractor
//
// Purpose: FSM state encoding, counter sizing helper and saturation constants
//          used by serial_addsub_nbit.
// Ports:   none (package).
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand the saturation helpers can describe.
  localparam int SAT_W = 64;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Largest positive two's-complement value of a w-bit word (0 then ones).
  function automatic logic [SAT_W-1:0] SAT_MAX(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  // Most negative two's-complement value of a w-bit word (1 then zeros).
  function automatic logic [SAT_W-1:0] SAT_MIN(input int w);
    return SAT_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - combinational DIGIT-bit ripple-carry adder slice
//
// Purpose: adds one digit of each operand plus a carry-in.
// Ports:
//   x, y   in  DIGIT  operand digits
//   cin    in  1      carry into bit 0 of the digit
//   s      out DIGIT  sum digit
//   cout   out 1      carry out of the top bit of the digit
//   c_msb  out 1      carry into the top bit of the digit (for overflow)
module serial_digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_nbit.sv
// rtl/serial_addsub_nbit.sv - handshaked bit-serial adder/subtractor, DIGIT bits per clock
//
// Purpose: accepts A, B and mode on an input handshake, adds or subtracts them
//          LSB digit first over WIDTH/DIGIT cycles, then presents the result on
//          an output handshake.
// Optional feature: define SERIAL_ADDSUB_SAT_EN to saturate the sum on signed
//          overflow; otherwise the sum wraps modulo 2^WIDTH.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   in_valid   in  1      operands and mode valid
//   in_ready   out 1      block can accept operands (IDLE only)
//   a, b       in  WIDTH  operands
//   sub        in  1      0: A+B, 1: A-B
//   out_valid  out 1      result valid (DONE)
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  result
//   cout       out 1      carry out of MSB (subtract: 1 = no borrow)
//   ovf        out 1      two's-complement overflow
module serial_addsub_nbit
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q, out_valid_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout, dig_c_msb;
  logic [WIDTH-1:0] a_d, b_d, sum_d, sum_fin_d;
  logic [CW-1:0]    cnt_d;
  logic             ovf_d, last_dig;

  serial_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (dig_s),
    .cout  (dig_cout),
    .c_msb (dig_c_msb)
  );

  assign a_d      = a_q >> DIGIT;
  assign b_d      = b_q >> DIGIT;
  assign cnt_d    = cnt_q + CW'(1);
  assign last_dig = (cnt_q == LAST_DIG);
  // On the last digit the adder's top bit is result bit WIDTH-1.
  assign ovf_d    = dig_c_msb ^ dig_cout;

  // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_sum_full
    assign sum_d = dig_s;
  end else begin : g_sum_shift
    assign sum_d = {dig_s, sum_q[WIDTH-1:DIGIT]};
  end

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [SAT_W-1:0] SAT_MAX_W = SAT_MAX(WIDTH);
  localparam logic [SAT_W-1:0] SAT_MIN_W = SAT_MIN(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS   = SAT_MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG   = SAT_MIN_W[WIDTH-1:0];

  // A wrapped negative sign means the true result was too positive, and vice versa.
  assign sum_fin_d = ovf_d ? (dig_s[DIGIT-1] ? SAT_POS : SAT_NEG) : sum_d;
`else
  assign sum_fin_d = sum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            sum_q   <= '0;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= dig_cout;
          cnt_q   <= cnt_d;
          if (last_dig) begin
            sum_q       <= sum_fin_d;
            cout_q      <= dig_cout;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sum_q <= sum_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_nbit.sv
// tb/tb_serial_addsub_nbit.sv - scoreboard bench for serial_addsub_nbit over several WIDTH/DIGIT builds
module tb_serial_addsub_nbit;

  localparam int NCFG = 5;
  localparam int NRND = 200;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic all_done;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic void model(input int w, input int av, input int bv, input bit s,
                                output int rs, output int rc, output int ro);
    int mask, tot, sa, sb, ex, smax, smin;
    mask = (1 << w) - 1;
    tot  = s ? (av + (1 << w) - bv) : (av + bv);
    rs   = tot & mask;
    rc   = (tot >> w) & 1;
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    ex   = s ? sa - sb : sa + sb;
    smax = (1 << (w - 1)) - 1;
    smin = -(1 << (w - 1));
    ro   = (ex > smax || ex < smin) ? 1 : 0;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ro == 1) rs = (ex > smax) ? smax : (1 << (w - 1));
`endif
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W    = (g < 3) ? 8 : 16;
    localparam int D    = (g == 0 || g == 3) ? 1 : ((g == 1) ? 2 : 4);
    localparam int NDIG = W / D;
    localparam int RST_WAIT = (NDIG - 1 < 3) ? NDIG - 1 : 3;

    logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    int           e_sum[$], e_c[$], e_o[$], e_t[$];
    int           cur_sum, cur_c, cur_o, hold;
    bit           pending, done;

    serial_addsub_nbit #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
    );

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int av, input int bv, input bit s, input bit push);
      int n, rs, rc, ro;
      a = W'(av);
      b = W'(bv);
      sub = s;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_accept", g), int'(in_ready), 1);
      if (in_ready && push) begin
        model(W, int'(a), int'(b), s, rs, rc, ro);
        e_sum.push_back(rs);
        e_c.push_back(rc);
        e_o.push_back(ro);
        e_t.push_back(cyc + 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while ((e_sum.size() != 0 || out_valid) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_drain", g), int'(e_sum.size() == 0 && !out_valid), 1);
    endtask

    // Monitor: pops the scoreboard when a result first appears, then checks it stays put.
    initial begin
      out_ready = 1'b0;
      pending = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          out_ready = 1'b0;
          pending = 1'b0;
        end else if (out_valid) begin
          if (!pending) begin
            pending = 1'b1;
            if (e_sum.size() == 0) begin
              chk($sformatf("c%0d_unexpected_out", g), 1, 0);
              cur_sum = int'(sum);
              cur_c = int'(cout);
              cur_o = int'(ovf);
            end else begin
              cur_sum = e_sum.pop_front();
              cur_c = e_c.pop_front();
              cur_o = e_o.pop_front();
              chk($sformatf("c%0d_latency", g), cyc - e_t.pop_front(), NDIG);
              chk($sformatf("c%0d_sum", g), int'(sum), cur_sum);
              chk($sformatf("c%0d_cout", g), int'(cout), cur_c);
              chk($sformatf("c%0d_ovf", g), int'(ovf), cur_o);
            end
          end else begin
            chk($sformatf("c%0d_hold_sum", g), int'(sum), cur_sum);
            chk($sformatf("c%0d_hold_cout", g), int'(cout), cur_c);
            chk($sformatf("c%0d_hold_ovf", g), int'(ovf), cur_o);
          end
          chk($sformatf("c%0d_busy_in_ready", g), int'(in_ready), 0);
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
          if (out_ready) pending = 1'b0;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end

    // Driver
    initial begin
      int n;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      sub = 1'b0;
      hold = 0;
      done = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("c%0d_rst_out_valid", g), int'(out_valid), 0);
      chk($sformatf("c%0d_rst_sum", g), int'(sum), 0);
      chk($sformatf("c%0d_rst_cout", g), int'(cout), 0);
      chk($sformatf("c%0d_rst_ovf", g), int'(ovf), 0);
      chk($sformatf("c%0d_rst_in_ready", g), int'(in_ready), 0);
      rst = 1'b0;
      #1;
      chk($sformatf("c%0d_idle_in_ready", g), int'(in_ready), 1);
      @(negedge clk);

      issue('h3C, 'h05, 1'b0, 1'b1);
      issue('h10, 'h20, 1'b1, 1'b1);
      issue('h7F, 'h01, 1'b0, 1'b1);
      drain();

      // Backpressure: result held 5 cycles while in_valid pulses are ignored.
      hold = 5;
      issue('hFF, 'h01, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("c%0d_hold_seen", g), int'(out_valid), 1);
      repeat (2) begin
        a = W'($urandom);
        b = W'($urandom);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
      end
      drain();

      // Abort mid-operation, then confirm no stale carry leaks into the next one.
      issue('h5A, 'h33, 1'b1, 1'b0);
      repeat (RST_WAIT) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk($sformatf("c%0d_abort_out_valid", g), int'(out_valid), 0);
      chk($sformatf("c%0d_abort_sum", g), int'(sum), 0);
      chk($sformatf("c%0d_abort_in_ready", g), int'(in_ready), 0);
      rst = 1'b0;
      #1;
      chk($sformatf("c%0d_abort_idle", g), int'(in_ready), 1);
      @(negedge clk);
      issue('h01, 'h01, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < NRND; i++) begin
        if ($urandom_range(0, 7) == 0) @(negedge clk);
        issue(int'($urandom), int'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end
      drain();
      done = 1'b1;
    end
  end

  assign all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done &&
                    g_cfg[3].done && g_cfg[4].done;

  initial begin
    for (int t = 0; t < 90000 && !all_done; t++) @(posedge clk);
    chk("all_done", int'(all_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
